// File: rtl/mac_pkg.sv
// Shared types and constants for the radix-4 multiply-accumulate unit.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [1:0] DIG_ZERO  = 2'd0;
  localparam logic [1:0] DIG_ONE   = 2'd1;
  localparam logic [1:0] DIG_TWO   = 2'd2;
  localparam logic [1:0] DIG_THREE = 2'd3;

  // Digit counter must reach WIDTH/2 (the finalise step), hence the +1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/radix4_pp_sel.sv
// Radix-4 partial-product select: picks 0, w, 2w or 3w for one 2-bit multiplier digit.
module radix4_pp_sel
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] w_i,
  input  logic [WIDTH+1:0] w3_i,
  input  logic [1:0]       digit_i,
  output logic [WIDTH+1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    case (digit_i)
      DIG_ZERO:  pp_o = '0;
      DIG_ONE:   pp_o = (WIDTH + 2)'(w_i);
      DIG_TWO:   pp_o = (WIDTH + 2)'({w_i, 1'b0});
      DIG_THREE: pp_o = w3_i;
      default:   pp_o = '0;
    endcase
  end

endmodule

// File: rtl/radix4_mac.sv
// Iterative unsigned MAC: retires two multiplier bits per cycle into a partial sum,
// then overwrites or accumulates the product into a wide sticky-overflow accumulator.
module radix4_mac
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  input  logic             acc_en,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2);

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH+1:0] w3_q;
  logic             acc_en_q;
  logic [PW-1:0]    partial_q;
  logic [CW-1:0]    cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic [WIDTH+1:0] pp;
  logic [PW-1:0]    partial_d;
  logic [ACC_W:0]   sum_d;

  // x_q is shifted right each digit, so the current digit is always its low pair.
  radix4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .w_i    (w_q),
    .w3_i   (w3_q),
    .digit_i(x_q[1:0]),
    .pp_o   (pp)
  );

  always_comb begin
    partial_d = partial_q + (PW'(pp) << {cnt_q, 1'b0});
    sum_d     = {1'b0, acc_q} + (ACC_W + 1)'(partial_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      w_q       <= '0;
      w3_q      <= '0;
      acc_en_q  <= 1'b0;
      partial_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A clear alongside an accept zeroes acc first; the add then lands on 0.
          if (clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (in_valid) begin
            x_q       <= x;
            w_q       <= w;
            w3_q      <= (WIDTH + 2)'(w) + (WIDTH + 2)'({w, 1'b0});
            acc_en_q  <= acc_en;
            partial_q <= '0;
            cnt_q     <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == LAST) begin
            if (acc_en_q) begin
              acc_q <= sum_d[ACC_W-1:0];
              ovf_q <= ovf_q | sum_d[ACC_W];
            end else begin
              acc_q <= ACC_W'(partial_q);
            end
            state_q <= DONE;
          end else begin
            partial_q <= partial_d;
            x_q       <= x_q >> 2;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_radix4_mac.sv
// Directed bench for radix4_mac at WIDTH=8/ACC_W=20 and WIDTH=2/ACC_W=4.
module tb_radix4_mac;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, acc_en8, clear8, out_valid8, out_ready8, ovf8;
  logic [7:0]  x8, w8;
  logic [19:0] y8;

  logic        in_valid2, in_ready2, acc_en2, clear2, out_valid2, out_ready2, ovf2;
  logic [1:0]  x2, w2;
  logic [3:0]  y2;

  int vecs;
  int errs;

  radix4_mac #(.WIDTH(8), .ACC_W(20)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .w(w8), .acc_en(acc_en8), .clear(clear8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .ovf(ovf8)
  );

  radix4_mac #(.WIDTH(2), .ACC_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x2), .w(w2), .acc_en(acc_en2), .clear(clear2), .out_valid(out_valid2),
    .out_ready(out_ready2), .y(y2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_ready8();
    int n;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready8) begin
      vecs++; errs++;
      $display("FAIL wait_ready8: in_ready=%b required 1", in_ready8);
    end
  endtask

  task automatic do_op8(input logic [7:0] xv, input logic [7:0] wv,
                        input logic ae, input logic cl, output int lat);
    wait_ready8();
    x8 = xv; w8 = wv; acc_en8 = ae; clear8 = cl; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; clear8 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (out_valid8) break;
    end
    if (!out_valid8) begin
      vecs++; errs++;
      $display("FAIL op8_timeout: out_valid=%b required 1", out_valid8);
      lat = -1;
    end
  endtask

  task automatic do_op2(input logic [1:0] xv, input logic [1:0] wv, output int lat);
    int n;
    n = 0;
    while (!in_ready2 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    x2 = xv; w2 = wv; acc_en2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (out_valid2) break;
    end
    if (!out_valid2) begin
      vecs++; errs++;
      $display("FAIL op2_timeout: out_valid=%b required 1", out_valid2);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    vecs++; if (in_ready8 !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b required 1", in_ready8); end
    vecs++; if (out_valid8 !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b required 0", out_valid8); end
    vecs++; if (y8 !== 20'd0) begin errs++; $display("FAIL reset_y: got %0d required 0", y8); end
    vecs++; if (ovf8 !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b required 0", ovf8); end
    vecs++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || y2 !== 4'd0) begin
      errs++; $display("FAIL reset_w2: in_ready=%b out_valid=%b y=%0d required 1 0 0", in_ready2, out_valid2, y2);
    end
  endtask

  task automatic test_max_operands();
    int lat;
    do_op8(8'd255, 8'd255, 1'b0, 1'b0, lat);
    vecs++; if (lat != 5) begin errs++; $display("FAIL max_latency: got %0d required 5", lat); end
    vecs++; if (y8 !== 20'h0FE01) begin errs++; $display("FAIL max_y: got %0d required 65025", y8); end
    vecs++; if (ovf8 !== 1'b0) begin errs++; $display("FAIL max_ovf: got %b required 0", ovf8); end
  endtask

  task automatic test_accumulate();
    int lat;
    do_op8(8'd3, 8'd7, 1'b0, 1'b0, lat);
    vecs++; if (y8 !== 20'd21) begin errs++; $display("FAIL acc_3x7: got %0d required 21", y8); end
    do_op8(8'd10, 8'd10, 1'b1, 1'b0, lat);
    vecs++; if (y8 !== 20'd121) begin errs++; $display("FAIL acc_10x10: got %0d required 121", y8); end
    do_op8(8'd2, 8'd2, 1'b1, 1'b1, lat);
    vecs++; if (y8 !== 20'd4) begin errs++; $display("FAIL acc_clear_2x2: got %0d required 4", y8); end
    vecs++; if (ovf8 !== 1'b0) begin errs++; $display("FAIL acc_ovf: got %b required 0", ovf8); end
  endtask

  task automatic test_overflow();
    int lat;
    do_op8(8'd255, 8'd255, 1'b0, 1'b0, lat);
    for (int i = 1; i < 17; i++) begin
      do_op8(8'd255, 8'd255, 1'b1, 1'b0, lat);
      if (i == 15) begin
        vecs++; if (ovf8 !== 1'b0) begin errs++; $display("FAIL ovf_early: got %b required 0 after 16 ops", ovf8); end
      end
    end
    vecs++; if (y8 !== 20'd56849) begin errs++; $display("FAIL ovf_wrap_y: got %0d required 56849", y8); end
    vecs++; if (ovf8 !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b required 1", ovf8); end
    do_op8(8'd1, 8'd1, 1'b0, 1'b0, lat);
    vecs++; if (y8 !== 20'd1) begin errs++; $display("FAIL ovf_overwrite_y: got %0d required 1", y8); end
    vecs++; if (ovf8 !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b required 1", ovf8); end
    wait_ready8();
    clear8 = 1'b1;
    @(posedge clk); #1;
    clear8 = 1'b0;
    vecs++; if (ovf8 !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b required 0", ovf8); end
    vecs++; if (y8 !== 20'd0) begin errs++; $display("FAIL clear_y: got %0d required 0", y8); end
  endtask

  task automatic test_backpressure();
    int lat;
    int extra;
    out_ready8 = 1'b0;
    do_op8(8'd6, 8'd9, 1'b0, 1'b0, lat);
    vecs++; if (lat != 5) begin errs++; $display("FAIL bp_latency: got %0d required 5", lat); end
    for (int i = 0; i < 3; i++) begin
      x8 = 8'd1; w8 = 8'd1; in_valid8 = (i == 1);
      @(posedge clk); #1;
      vecs++; if (out_valid8 !== 1'b1 || y8 !== 20'd54 || in_ready8 !== 1'b0) begin
        errs++; $display("FAIL bp_hold: out_valid=%b y=%0d in_ready=%b required 1 54 0", out_valid8, y8, in_ready8);
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    vecs++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errs++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid8, in_ready8);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid8) extra++;
    end
    vecs++; if (extra != 0) begin errs++; $display("FAIL bp_no_extra: got %0d results required 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    wait_ready8();
    x8 = 8'd200; w8 = 8'd100; acc_en8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vecs++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errs++; $display("FAIL rst_run_hs: in_ready=%b out_valid=%b required 1 0", in_ready8, out_valid8);
    end
    vecs++; if (y8 !== 20'd0 || ovf8 !== 1'b0) begin
      errs++; $display("FAIL rst_run_acc: y=%0d ovf=%b required 0 0", y8, ovf8);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid8) seen++;
    end
    vecs++; if (seen != 0 || y8 !== 20'd0) begin
      errs++; $display("FAIL rst_run_no_result: results=%0d y=%0d required 0 0", seen, y8);
    end
  endtask

  task automatic test_width2();
    int lat;
    logic [3:0] exp;
    for (int xi = 0; xi < 4; xi++) begin
      for (int wi = 0; wi < 4; wi++) begin
        do_op2(2'(xi), 2'(wi), lat);
        exp = 4'(xi * wi);
        vecs++; if (y2 !== exp || lat != 2) begin
          errs++; $display("FAIL w2_%0dx%0d: y=%0d lat=%0d required y=%0d lat=2", xi, wi, y2, lat, exp);
        end
      end
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst_n = 1'b0;
    in_valid8 = 1'b0; x8 = '0; w8 = '0; acc_en8 = 1'b0; clear8 = 1'b0; out_ready8 = 1'b1;
    in_valid2 = 1'b0; x2 = '0; w2 = '0; acc_en2 = 1'b0; clear2 = 1'b0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_max_operands();
    test_accumulate();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
